// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave backed by a word-addressed SRAM array.
// Configuration macro: AHB_SRAM_WAIT_EN. When it is defined, each legal
// transfer gets WAIT_STATES HREADYOUT-low cycles before its data cycle.
// When it is undefined, WAIT_STATES is ignored and every legal transfer is
// zero-wait.
// Handshake: an address phase is taken on a rising HCLK edge when HSEL=1,
// HREADY=1 and HTRANS is NONSEQ or SEQ. Its data phase completes on the
// first later edge where HREADYOUT=1.
// The FSM state is exported on dbg_state, and ST_IDLE encodes as 3'd0.
module ahb_sram_slave #(
  parameter int unsigned MEM_DEPTH   = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic [2:0]  HBURST,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [15:0] XFER_CNT,
  output logic [2:0]  dbg_state
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic       RESP_OKAY  = 1'b0;
  localparam logic       RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
`ifdef AHB_SRAM_WAIT_EN
    ST_WAIT = 3'd1,
`endif
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

`ifdef AHB_SRAM_WAIT_EN
  localparam logic [2:0] WS       = 3'(WAIT_STATES);
  localparam state_t     ST_LEGAL = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
  logic [2:0] wait_cnt_q;
`else
  localparam state_t     ST_LEGAL = ST_DATA;
`endif

  state_t        state_q, state_d;
  logic [31:0]   mem [0:MEM_DEPTH-1];
  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic [15:0]   xfer_cnt_q;
  logic [31:0]   index;
  logic          accept, legal, take;
  logic          unused_bits;

  // Address-phase decode: the offset from BASE_ADDR is unsigned, so addresses below the base wrap high and fail the range test.
  assign accept = HSEL && HREADY && (HTRANS == TR_NONSEQ || HTRANS == TR_SEQ);
  assign index  = HADDR - BASE_ADDR;
  assign legal  = (index < 32'(MEM_DEPTH)) && (HSIZE == SIZE_WORD);

  assign XFER_CNT    = xfer_cnt_q;
  assign dbg_state   = state_q;
  assign unused_bits = ^{HBURST, index[31:AW], 32'(WAIT_STATES)};

  // Next state and bus outputs. ST_DATA and ST_ERR2 leave HREADYOUT high, so they can take a new address phase just as ST_IDLE does.
  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = RESP_OKAY;
    HRDATA    = 32'h0;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (state_q == ST_DATA && !wr_q) HRDATA = mem[idx_q];
        if (state_q == ST_ERR2) HRESP = RESP_ERROR;
        take = accept;
        if (accept) state_d = legal ? ST_LEGAL : ST_ERR1;
        else        state_d = ST_IDLE;
      end
`ifdef AHB_SRAM_WAIT_EN
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt_q <= 3'd1) state_d = ST_DATA;
      end
`endif
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = RESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, address-phase capture and completion counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      xfer_cnt_q <= 16'h0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DATA) xfer_cnt_q <= xfer_cnt_q + 16'h1;
      if (take) begin
        idx_q <= index[AW-1:0];
        wr_q  <= HWRITE;
      end
    end
  end

`ifdef AHB_SRAM_WAIT_EN
  // Wait-state down-counter: it is loaded on entry to ST_WAIT and decremented while in that state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                wait_cnt_q <= 3'd0;
    else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q - 3'd1;
    else if (state_d == ST_WAIT) wait_cnt_q <= WS;
  end
`endif

  // Storage. It has no reset, and a write commits only on a completing ST_DATA edge.
  always_ff @(posedge HCLK) begin
    if (state_q == ST_DATA && wr_q) mem[idx_q] <= HWDATA;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed and random AHB transfers checked against a
// word-array model of the SRAM and a count of OKAY completions.
module tb_ahb_sram_slave;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;
`ifdef AHB_SRAM_WAIT_EN
  localparam int EXP_WAITS = 3;
`else
  localparam int EXP_WAITS = 0;
`endif
  localparam logic [1:0] TR_IDLE = 2'd0, TR_BUSY = 2'd1, TR_NONSEQ = 2'd2, TR_SEQ = 2'd3;
  localparam logic [2:0] SZ_BYTE = 3'd0, SZ_HALF = 3'd1, SZ_WORD = 3'd2;
  localparam logic [2:0] BURST_INCR = 3'd1;

  // ---------------- clock / reset / signals ----------------
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0, sel0 = 1'b0, HWRITE = 1'b0;
  logic [31:0] HADDR = 32'h0, HWDATA = 32'h0;
  logic [2:0]  HBURST = 3'd0, HSIZE = SZ_WORD;
  logic [1:0]  HTRANS = TR_IDLE;
  logic        HREADY, HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic [15:0] XFER_CNT;
  logic [2:0]  dbg_state;
  logic        hready0, hreadyout0, unused_hresp0;
  logic [31:0] unused_hrdata0;
  logic [15:0] xfer_cnt0;
  logic [2:0]  unused_dbg0;

  always #5 HCLK = ~HCLK;
  assign HREADY  = HREADYOUT;
  assign hready0 = hreadyout0;

  ahb_sram_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .XFER_CNT(XFER_CNT),
    .dbg_state(dbg_state));

  // The second instance is zero-wait and is used only for the counter-wrap run.
  ahb_sram_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(hready0),
    .HREADYOUT(hreadyout0), .HRESP(unused_hresp0), .HRDATA(unused_hrdata0),
    .XFER_CNT(xfer_cnt0), .dbg_state(unused_dbg0));

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] mem_m [0:DEPTH-1];
  int          cnt_m = 0;
  int          n_checks = 0, n_pass = 0, n_fail = 0;
  logic        p_wr   [4];
  logic [31:0] p_addr [4];
  logic [31:0] p_wd   [4];
  logic [31:0] p_rd   [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One non-pipelined transfer, called at a cycle start while the slave is ready.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, output logic [31:0] rdata, output int lows,
                         output logic resp);
    HSEL = 1'b1; HADDR = addr; HWRITE = wr; HSIZE = size; HTRANS = TR_NONSEQ; HBURST = 3'd0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = TR_IDLE; HWDATA = wdata;
    lows = 0;
    while (HREADYOUT !== 1'b1 && lows < 20) begin
      lows++;
      @(posedge HCLK); #1;
    end
    rdata = HRDATA;
    resp  = HRESP;
    @(posedge HCLK); #1;
  endtask

  // A back-to-back NONSEQ/SEQ sequence of n word transfers taken from the p_* arrays.
  task automatic pipe(input int n, output int lows);
    lows = 0;
    HSEL = 1'b1; HSIZE = SZ_WORD; HBURST = BURST_INCR;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HTRANS = (i == 0) ? TR_NONSEQ : TR_SEQ;
        HADDR  = p_addr[i];
        HWRITE = p_wr[i];
      end else begin
        HTRANS = TR_IDLE; HSEL = 1'b0; HWRITE = 1'b0;
      end
      HWDATA = (i > 0) ? p_wd[i-1] : 32'h0;
      for (int g = 0; g < 20 && HREADYOUT !== 1'b1; g++) begin
        lows++;
        @(posedge HCLK); #1;
      end
      if (i > 0) p_rd[i-1] = HRDATA;
      @(posedge HCLK); #1;
    end
  endtask

  // Single transfer with its outcome predicted from the address, size and model.
  task automatic bus_op(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size);
    logic [31:0] rdata, idx, exp_rd;
    int          lows;
    logic        resp, ok;
    idx    = addr - BASE;
    ok     = (idx < DEPTH) && (size == SZ_WORD);
    exp_rd = 32'h0;
    if (ok && !wr) exp_q.push_back(mem_m[idx[5:0]]);
    do_xfer(wr, addr, wdata, size, rdata, lows, resp);
    if (ok) begin
      check({tag, " waits"}, 32'(lows), 32'(EXP_WAITS));
      check({tag, " resp"}, 32'(resp), 32'h0);
      if (wr) mem_m[idx[5:0]] = wdata;
      else    exp_rd = exp_q.pop_front();
      cnt_m++;
    end else begin
      check({tag, " err low cycles"}, 32'(lows), 32'd1);
      check({tag, " err resp"}, 32'(resp), 32'h1);
    end
    check({tag, " rdata"}, rdata, exp_rd);
    check({tag, " xfer_cnt"}, 32'(XFER_CNT), 32'(cnt_m & 16'hFFFF));
  endtask

  // Sequence through the model in order, so a read sees any earlier write in the same sequence.
  task automatic pipe_op(input string tag, input int n);
    logic [31:0] idx;
    int          lows;
    for (int i = 0; i < n; i++) begin
      idx = p_addr[i] - BASE;
      if (p_wr[i]) mem_m[idx[5:0]] = p_wd[i];
      else         exp_q.push_back(mem_m[idx[5:0]]);
      cnt_m++;
    end
    pipe(n, lows);
    check({tag, " waits"}, 32'(lows), 32'(n * EXP_WAITS));
    for (int i = 0; i < n; i++) begin
      if (p_wr[i]) check({tag, " wr rdata"}, p_rd[i], 32'h0);
      else         check({tag, " rd data"}, p_rd[i], exp_q.pop_front());
    end
    check({tag, " xfer_cnt"}, 32'(XFER_CNT), 32'(cnt_m & 16'hFFFF));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d, idx, r;
    logic        wr;
    logic [2:0]  sz;

    // Reset values, checked while reset is held.
    repeat (3) begin @(posedge HCLK); #1; end
    check("rst hreadyout", 32'(HREADYOUT), 32'h1);
    check("rst hresp", 32'(HRESP), 32'h0);
    check("rst hrdata", HRDATA, 32'h0);
    check("rst xfer_cnt", 32'(XFER_CNT), 32'h0);
    check("rst state idle", 32'(dbg_state), 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // IDLE/BUSY with HSEL=1, and NONSEQ with HSEL=0, cause no access and no wait.
    HSEL = 1'b1; HTRANS = TR_IDLE; HADDR = BASE;
    @(posedge HCLK); #1;
    check("idle ready", 32'(HREADYOUT), 32'h1);
    HTRANS = TR_BUSY;
    @(posedge HCLK); #1;
    check("busy ready", 32'(HREADYOUT), 32'h1);
    HSEL = 1'b0; HTRANS = TR_NONSEQ;
    @(posedge HCLK); #1;
    check("unsel ready", 32'(HREADYOUT), 32'h1);
    check("unsel rdata", HRDATA, 32'h0);
    check("no access cnt", 32'(XFER_CNT), 32'h0);
    HTRANS = TR_IDLE;

    // Write, then read back, word 5.
    bus_op("w5", 1'b1, BASE + 5, 32'hA5A5_0001, SZ_WORD);
    bus_op("r5", 1'b0, BASE + 5, 32'h0, SZ_WORD);
    check("cnt after w/r", 32'(XFER_CNT), 32'd2);

    // Fill every word so later random reads are defined.
    for (int i = 0; i < DEPTH; i++) bus_op("fill", 1'b1, BASE + i, $urandom, SZ_WORD);

    // Burst of writes at decrementing addresses, then read back the same way.
    d = $urandom;
    for (int i = 0; i < 4; i++) begin
      p_wr[i] = 1'b1; p_addr[i] = BASE + 32'(10 - i); p_wd[i] = d + 32'(i);
    end
    pipe_op("burst wr", 4);
    for (int i = 0; i < 4; i++) p_wr[i] = 1'b0;
    pipe_op("burst rd", 4);

    // A write immediately followed by a read of the same word.
    for (int k = 0; k < 6; k++) begin
      idx = 32'($urandom_range(0, DEPTH - 1));
      p_wr[0] = 1'b1; p_addr[0] = BASE + idx; p_wd[0] = $urandom;
      p_wr[1] = 1'b0; p_addr[1] = BASE + idx; p_wd[1] = 32'h0;
      pipe_op("raw", 2);
    end

    // Error transfers leave memory and the counter untouched.
    bus_op("err range", 1'b1, BASE + 64, 32'hBAD0_0040, SZ_WORD);
    bus_op("err half", 1'b1, BASE + 5, 32'hBAD0_0005, SZ_HALF);
    bus_op("err byte rd", 1'b0, BASE + 7, 32'h0, SZ_BYTE);
    bus_op("err below", 1'b1, BASE - 1, 32'hBAD0_FFFF, SZ_WORD);
    bus_op("r0 kept", 1'b0, BASE + 0, 32'h0, SZ_WORD);
    bus_op("r5 kept", 1'b0, BASE + 5, 32'h0, SZ_WORD);

    // Random mix of reads, writes and error transfers.
    for (int k = 0; k < 40; k++) begin
      wr  = 1'($urandom_range(0, 1));
      idx = 32'($urandom_range(0, 71));
      r   = 32'($urandom_range(0, 7));
      sz  = (r == 0) ? SZ_HALF : ((r == 1) ? SZ_BYTE : SZ_WORD);
      bus_op("rand", wr, BASE + idx, $urandom, sz);
    end

    // Reset during the data phase of a write to word 3 aborts the write.
    HSEL = 1'b1; HTRANS = TR_NONSEQ; HWRITE = 1'b1; HSIZE = SZ_WORD; HADDR = BASE + 3;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = TR_IDLE; HWDATA = 32'hDEAD_0003;
    check("wait before reset", 32'(HREADYOUT), (EXP_WAITS > 0) ? 32'h0 : 32'h1);
    HRESETn = 1'b0;
    #1;
    check("mid rst hreadyout", 32'(HREADYOUT), 32'h1);
    check("mid rst hresp", 32'(HRESP), 32'h0);
    check("mid rst hrdata", HRDATA, 32'h0);
    check("mid rst xfer_cnt", 32'(XFER_CNT), 32'h0);
    cnt_m = 0;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    bus_op("r3 after rst", 1'b0, BASE + 3, 32'h0, SZ_WORD);

    // Counter wrap on the zero-wait instance. A continuous read stream completes one transfer per cycle.
    HSEL = 1'b0; sel0 = 1'b1; HTRANS = TR_NONSEQ; HWRITE = 1'b0; HSIZE = SZ_WORD; HADDR = BASE;
    repeat (65535) @(posedge HCLK);
    #1;
    check("dut0 ready in stream", 32'(hreadyout0), 32'h1);
    sel0 = 1'b0; HTRANS = TR_IDLE;
    @(posedge HCLK); #1;
    check("dut0 cnt ffff", 32'(xfer_cnt0), 32'h0000_FFFF);
    sel0 = 1'b1; HTRANS = TR_NONSEQ;
    @(posedge HCLK); #1;
    sel0 = 1'b0; HTRANS = TR_IDLE;
    @(posedge HCLK); #1;
    check("dut0 cnt wrap", 32'(xfer_cnt0), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, meaning number of 32-bit storage words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the HADDR value of word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0-7, meaning HREADYOUT-low cycles inserted per OKAY transfer.
REQ-004 SHALL have port HCLK  input  1  single bus clock; all logic on its rising edge.
REQ-005 SHALL have port HRESETn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port HSEL  input  1  slave select.
REQ-007 SHALL have port HADDR  input  32  word address; one address unit is one 32-bit word.
REQ-008 SHALL have port HWDATA  input  32  write data, data phase.
REQ-009 SHALL have port HWRITE  input  1  1 = write, 0 = read.
REQ-010 SHALL have port HBURST  input  HBURST_Type  burst type; accepted but not used for addressing.
REQ-011 SHALL have port HSIZE  input  3  transfer size; only WORD is legal.
REQ-012 SHALL have port HTRANS  input  HTRANS_state  IDLE/BUSY/NONSEQ/SEQ.
REQ-013 SHALL have port HREADY  input  1  bus-level ready; qualifies the address phase.
REQ-014 SHALL have port HREADYOUT  output  1  slave ready.
REQ-015 SHALL have port HRESP  output  HRESP_state  OKAY/ERROR.
REQ-016 SHALL have port HRDATA  output  32  read data.
REQ-017 SHALL have port XFER_CNT  output  16  count of completed OKAY transfers.

Function
REQ-018 Address phase SHALL be accepted when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; HADDR, HWRITE and HSIZE SHALL be registered at that edge.
REQ-019 An address phase with HTRANS IDLE or BUSY, or with HSEL=0, SHALL cause no access and a zero-wait OKAY response.
REQ-020 Index SHALL be HADDR-BASE_ADDR in 32-bit unsigned arithmetic; index >= MEM_DEPTH or HSIZE != WORD SHALL be an error transfer.
REQ-021 FSM states SHALL be ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2.
REQ-022 From ST_IDLE, or from ST_DATA while another transfer is accepted, a legal transfer SHALL go to ST_WAIT if WAIT_STATES>0, else to ST_DATA; an error transfer SHALL go to ST_ERR1; otherwise the FSM SHALL go to ST_IDLE.
REQ-023 ST_WAIT SHALL drive HREADYOUT=0 and HRESP=OKAY for exactly WAIT_STATES cycles using a 3-bit down-counter, then go to ST_DATA.
REQ-024 ST_DATA SHALL drive HREADYOUT=1 and HRESP=OKAY; the transfer SHALL complete at this edge; a write SHALL store HWDATA to mem[index]; a read SHALL present mem[index] on HRDATA in this cycle.
REQ-025 ST_ERR1 SHALL drive HREADYOUT=0, HRESP=ERROR; ST_ERR2 SHALL drive HREADYOUT=1, HRESP=ERROR, then behave as ST_IDLE; error transfers SHALL NOT modify memory or XFER_CNT.
REQ-026 A read immediately following a write to the same index SHALL return the newly written data.
REQ-027 XFER_CNT SHALL increment by 1 on each OKAY completion and wrap from 16'hFFFF to 16'h0000.
REQ-028 HRDATA SHALL be 32'h0 in every cycle except a read ST_DATA cycle.
REQ-029 An address phase presented while HREADYOUT=0 SHALL be ignored, because HREADY=0 on the bus.

Reset
REQ-030 HRESETn=0 SHALL immediately force ST_IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, XFER_CNT=0 and wait counter=0.
REQ-031 Reset during ST_WAIT or ST_ERR1 SHALL abort the transfer with no memory write; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With macro AHB_SRAM_WAIT_EN defined, wait-state insertion per REQ-023 SHALL be compiled in.
REQ-033 Without AHB_SRAM_WAIT_EN, WAIT_STATES SHALL be ignored, ST_WAIT and its counter SHALL be absent, and every legal transfer SHALL be zero-wait.

Verification
REQ-034 NONSEQ write HADDR=BASE_ADDR+5, HWDATA=32'hA5A5_0001, then NONSEQ read of the same address -> read returns 32'hA5A5_0001; XFER_CNT=2.
REQ-035 WAIT_STATES=3 with AHB_SRAM_WAIT_EN defined, single read -> HREADYOUT low for exactly 3 cycles, then high with data; without the macro -> 0 low cycles.
REQ-036 Burst of 4 NONSEQ/SEQ writes at decrementing addresses 10,9,8,7 with data D, D+1, D+2, D+3 -> read-back matches; XFER_CNT=8 after the reads.
REQ-037 Write to HADDR=BASE_ADDR+64 (MEM_DEPTH=64), and separately HSIZE=HALFWORD -> ERROR for 2 cycles (HREADYOUT 0 then 1); memory and XFER_CNT unchanged.
REQ-038 HRESETn asserted mid-ST_WAIT of a write to index 3 -> outputs reset immediately; mem[3] keeps its old value.
REQ-039 XFER_CNT preloaded to 16'hFFFF via 65535 transfers, then one more OKAY transfer -> XFER_CNT=16'h0000.
